video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised, runtime-reprogrammable raster timing generator that produces HS/VS/DE, active-pixel coordinates and frame/line strobes for display and test-pattern paths. It replaces the fixed 640x480, one-pixel-per-clock generator used by the CSI receive testbench. It adds multi-pixel-per-clock output, selectable sync polarity, shadowed timing registers applied only at frame boundaries, and a run/hold control. It sits ahead of the pixel source and the output formatter.

## Interface
- CNT_WIDTH, 12: width of every timing field, counter and coordinate.
- PPC, 1: pixels per clock, legal values 1, 2 or 4.
- HS_ACTIVE_HIGH, 0: 1 means out_hs is high during the sync pulse; 0 means it is low.
- VS_ACTIVE_HIGH, 0: the same rule, applied to out_vs.
- DEF_H_SYNC / DEF_H_BP / DEF_H_ACT / DEF_H_FP, 96/48/640/16: horizontal timing applied at reset, in pixels.
- DEF_V_SYNC / DEF_V_BP / DEF_V_ACT / DEF_V_FP, 2/33/480/10: vertical timing applied at reset, in lines.

Ports:
- in_pclk  in  1  pixel clock. There is one clock domain.
- in_rst  in  1  reset, synchronous and active-high.
- in_enable  in  1  1 lets the counters run; 0 holds them.
- in_cfg_load  in  1  single-cycle pulse that captures all in_cfg_* fields.
- in_cfg_h_sync, in_cfg_h_bp, in_cfg_h_act, in_cfg_h_fp  in  CNT_WIDTH each  new horizontal timing, in pixels.
- in_cfg_v_sync, in_cfg_v_bp, in_cfg_v_act, in_cfg_v_fp  in  CNT_WIDTH each  new vertical timing, in lines.
- out_cfg_pending  out  1  a captured configuration is waiting for the frame boundary.
- out_x  out  CNT_WIDTH  pixel index of lane 0 during DE; 0 otherwise.
- out_y  out  CNT_WIDTH  active line index during DE; 0 otherwise.
- out_de, out_hs, out_vs  out  1 each  data enable and the two syncs.
- out_sof  out  1  high for one beat, on the first active beat of a frame.
- out_eol  out  1  high for one beat, on the last active beat of each line.

## Operation
- Horizontal counter h:
  - advances by PPC per enabled clock.
  - wraps to 0 when h + PPC == HT, where HT = h_sync + h_bp + h_act + h_fp.
  - all horizontal fields must be multiples of PPC; behaviour is undefined otherwise.
- Vertical counter v:
  - advances by 1 when h wraps.
  - wraps to 0 when it is at VT-1 and h wraps, where VT is the vertical total.
- Sync and data enable:
  - HS is active while h < h_sync.
  - VS is active while v < v_sync.
  - DE is high while h is in [h_sync+h_bp, h_sync+h_bp+h_act) and v is in [v_sync+v_bp, v_sync+v_bp+v_act).
  - A sync field of zero means that sync is never active.
  - h_act and v_act must be nonzero.
- Coordinates:
  - out_x = h − (h_sync+h_bp), stepping by PPC.
  - out_y = v − (v_sync+v_bp).
  - both are 0 outside DE.
- Strobes:
  - out_sof requires DE with out_x=0 and out_y=0.
  - out_eol requires DE with out_x = h_act − PPC.
- Arithmetic: sums are computed at CNT_WIDTH+1 bits. HT and VT must fit in CNT_WIDTH bits; behaviour is undefined otherwise.
- Configuration:
  - in_cfg_load copies every in_cfg_* field into the pending registers and sets out_cfg_pending.
  - The pending values become active on the edge where both h and v wrap (frame wrap). out_cfg_pending clears on that same edge.
  - A load on the same cycle as a frame wrap is held for the next wrap.
  - A load while a configuration is pending overwrites the pending values.
- Hold (in_enable=0):
  - h and v hold.
  - out_de, out_sof and out_eol are forced to 0; out_x and out_y are forced to 0.
  - out_hs and out_vs keep the last value from the counters.
  - Configuration capture still works. A frame wrap cannot occur while held.
- Reset:
  - h=v=0, and the active and pending configuration load the DEF_* values.
  - out_cfg_pending=0, out_de=out_sof=out_eol=0, out_x=out_y=0.
  - out_hs and out_vs go to their inactive levels.
  - Reset asserted mid-frame takes effect on the next edge with no drain.

## Timing
- All outputs are registered, one cycle after the counter state they decode.
- The first edge with in_rst=0 and in_enable=1 presents h=v=0. On the following edge, out_hs and out_vs go active if h_sync and v_sync are nonzero.
- Line period is HT/PPC clocks; frame period is VT·HT/PPC clocks.
- A new configuration affects outputs starting from the first cycle of the frame after the wrap edge.

## Structure
- Package video_timing_pkg contains:
  - the typedef timing_cfg_t (the eight CNT_WIDTH fields);
  - the constant TIMING_640x480 built from the DEF_* defaults;
  - a function that computes the DE start and end positions.
- Sub-module timing_axis_cnt:
  - ports: count, step, total, wrap-in enable, wrap-out.
  - instanced twice: horizontal with step PPC, vertical with step 1.

## Test plan
- Small configuration H 2/2/4/2 and V 1/1/3/1, PPC=1, after reset:
  - line period 10 clocks; out_hs active 2 beats per line; DE 4 beats per line with out_x 0,1,2,3;
  - out_y 0..2; frame period 60 clocks; out_sof once per frame.
- Same configuration with PPC=2:
  - line period 5 clocks; out_x 0,2 per line; out_eol at out_x=2.
- in_cfg_load mid-frame, changing h_act from 4 to 6:
  - out_cfg_pending=1 until the frame wrap;
  - the current frame keeps 4 DE beats per line; the next frame has 6 beats and a 12-clock line.
- Load coinciding with the wrap edge:
  - the new configuration is applied at the following wrap; out_cfg_pending stays 1 for a full frame.
- in_enable low for 7 clocks during DE at out_x=1:
  - out_de=0 throughout the hold;
  - after release, output resumes at out_x=1 and the line/frame count is unchanged.
- in_rst asserted mid-line:
  - the next cycle shows all outputs at their reset values;
  - the DEF_* timing is restored and out_cfg_pending=0;
  - with HS_ACTIVE_HIGH=1, out_hs is 0 in reset and 1 during sync.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared timing types, the 640x480 default raster and DE-window helpers
// for the raster timing generator.
package video_timing_pkg;

  // Widest timing field the generator supports; narrower CNT_WIDTH values zero-extend.
  localparam int TIMING_W = 16;

  typedef logic [TIMING_W:0] tsum_t;

  typedef struct packed {
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_bp;
    logic [TIMING_W-1:0] h_act;
    logic [TIMING_W-1:0] h_fp;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_bp;
    logic [TIMING_W-1:0] v_act;
    logic [TIMING_W-1:0] v_fp;
  } timing_cfg_t;

  typedef struct packed {
    tsum_t start;
    tsum_t stop;
  } de_win_t;

  localparam timing_cfg_t TIMING_640x480 = '{
    h_sync: TIMING_W'(96),  h_bp: TIMING_W'(48), h_act: TIMING_W'(640), h_fp: TIMING_W'(16),
    v_sync: TIMING_W'(2),   v_bp: TIMING_W'(33), v_act: TIMING_W'(480), v_fp: TIMING_W'(10)
  };

  // Active window on one axis: [sync+bp, sync+bp+act).
  function automatic de_win_t de_window(input logic [TIMING_W-1:0] sync, bp, act);
    de_win_t w;
    w.start = tsum_t'(sync) + tsum_t'(bp);
    w.stop  = w.start + tsum_t'(act);
    return w;
  endfunction

  function automatic tsum_t axis_total(input logic [TIMING_W-1:0] sync, bp, act, fp);
    return tsum_t'(sync) + tsum_t'(bp) + tsum_t'(act) + tsum_t'(fp);
  endfunction

endpackage

// File: rtl/video_timing_gen_axis_cnt.sv
// One raster axis: advances by step when enabled, wraps to 0 on reaching total.
module timing_axis_cnt #(
  parameter int W = 12
) (
  input  logic         in_pclk,
  input  logic         in_rst,
  input  logic         wrap_en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] total,
  output logic [W-1:0] count,
  output logic         wrap
);

  logic [W:0] nxt;

  assign nxt  = {1'b0, count} + {1'b0, step};
  assign wrap = wrap_en && (nxt == {1'b0, total});

  always_ff @(posedge in_pclk) begin
    if (in_rst)       count <= '0;
    else if (wrap_en) count <= wrap ? '0 : nxt[W-1:0];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Runtime-reprogrammable raster timing generator: HS/VS/DE, coordinates and
// SOF/EOL strobes, PPC pixels per clock, shadow config applied at frame wrap.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CNT_WIDTH      = 12,
  parameter int PPC            = 1,
  parameter bit HS_ACTIVE_HIGH = 1'b0,
  parameter bit VS_ACTIVE_HIGH = 1'b0,
  parameter int DEF_H_SYNC     = int'(TIMING_640x480.h_sync),
  parameter int DEF_H_BP       = int'(TIMING_640x480.h_bp),
  parameter int DEF_H_ACT      = int'(TIMING_640x480.h_act),
  parameter int DEF_H_FP       = int'(TIMING_640x480.h_fp),
  parameter int DEF_V_SYNC     = int'(TIMING_640x480.v_sync),
  parameter int DEF_V_BP       = int'(TIMING_640x480.v_bp),
  parameter int DEF_V_ACT      = int'(TIMING_640x480.v_act),
  parameter int DEF_V_FP       = int'(TIMING_640x480.v_fp)
) (
  input  logic                 in_pclk,
  input  logic                 in_rst,
  input  logic                 in_enable,
  input  logic                 in_cfg_load,
  input  logic [CNT_WIDTH-1:0] in_cfg_h_sync,
  input  logic [CNT_WIDTH-1:0] in_cfg_h_bp,
  input  logic [CNT_WIDTH-1:0] in_cfg_h_act,
  input  logic [CNT_WIDTH-1:0] in_cfg_h_fp,
  input  logic [CNT_WIDTH-1:0] in_cfg_v_sync,
  input  logic [CNT_WIDTH-1:0] in_cfg_v_bp,
  input  logic [CNT_WIDTH-1:0] in_cfg_v_act,
  input  logic [CNT_WIDTH-1:0] in_cfg_v_fp,
  output logic                 out_cfg_pending,
  output logic [CNT_WIDTH-1:0] out_x,
  output logic [CNT_WIDTH-1:0] out_y,
  output logic                 out_de,
  output logic                 out_hs,
  output logic                 out_vs,
  output logic                 out_sof,
  output logic                 out_eol
);

  localparam timing_cfg_t DEF_CFG = '{
    h_sync: TIMING_W'(DEF_H_SYNC), h_bp: TIMING_W'(DEF_H_BP),
    h_act:  TIMING_W'(DEF_H_ACT),  h_fp: TIMING_W'(DEF_H_FP),
    v_sync: TIMING_W'(DEF_V_SYNC), v_bp: TIMING_W'(DEF_V_BP),
    v_act:  TIMING_W'(DEF_V_ACT),  v_fp: TIMING_W'(DEF_V_FP)
  };
  localparam bit HS_ON = HS_ACTIVE_HIGH;
  localparam bit VS_ON = VS_ACTIVE_HIGH;

  timing_cfg_t act_cfg, pend_cfg, cfg_in;
  logic [CNT_WIDTH-1:0] h, v;
  logic h_wrap, v_wrap, frame_wrap;
  logic run_q, adv;

  assign cfg_in = '{
    h_sync: TIMING_W'(in_cfg_h_sync), h_bp: TIMING_W'(in_cfg_h_bp),
    h_act:  TIMING_W'(in_cfg_h_act),  h_fp: TIMING_W'(in_cfg_h_fp),
    v_sync: TIMING_W'(in_cfg_v_sync), v_bp: TIMING_W'(in_cfg_v_bp),
    v_act:  TIMING_W'(in_cfg_v_act),  v_fp: TIMING_W'(in_cfg_v_fp)
  };

  // The first enabled edge after reset only arms run_q, so h=v=0 is decoded on the next one.
  always_ff @(posedge in_pclk) begin
    if (in_rst)         run_q <= 1'b0;
    else if (in_enable) run_q <= 1'b1;
  end

  assign adv        = in_enable && run_q;
  assign frame_wrap = v_wrap;

  timing_axis_cnt #(.W(CNT_WIDTH)) u_h_cnt (
    .in_pclk (in_pclk),
    .in_rst  (in_rst),
    .wrap_en (adv),
    .step    (CNT_WIDTH'(PPC)),
    .total   (CNT_WIDTH'(axis_total(act_cfg.h_sync, act_cfg.h_bp, act_cfg.h_act, act_cfg.h_fp))),
    .count   (h),
    .wrap    (h_wrap)
  );

  timing_axis_cnt #(.W(CNT_WIDTH)) u_v_cnt (
    .in_pclk (in_pclk),
    .in_rst  (in_rst),
    .wrap_en (h_wrap),
    .step    (CNT_WIDTH'(1)),
    .total   (CNT_WIDTH'(axis_total(act_cfg.v_sync, act_cfg.v_bp, act_cfg.v_act, act_cfg.v_fp))),
    .count   (v),
    .wrap    (v_wrap)
  );

  // A load always wins over a coincident wrap, so it waits for the following frame.
  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      act_cfg         <= DEF_CFG;
      pend_cfg        <= DEF_CFG;
      out_cfg_pending <= 1'b0;
    end else if (in_cfg_load) begin
      pend_cfg        <= cfg_in;
      out_cfg_pending <= 1'b1;
    end else if (frame_wrap && out_cfg_pending) begin
      act_cfg         <= pend_cfg;
      out_cfg_pending <= 1'b0;
    end
  end

  de_win_t hwin, vwin;
  tsum_t   h_ext, v_ext;
  logic    h_in, v_in, de_c, hs_c, vs_c, sof_c, eol_c;
  logic [CNT_WIDTH-1:0] x_c, y_c;

  assign hwin  = de_window(act_cfg.h_sync, act_cfg.h_bp, act_cfg.h_act);
  assign vwin  = de_window(act_cfg.v_sync, act_cfg.v_bp, act_cfg.v_act);
  assign h_ext = tsum_t'(h);
  assign v_ext = tsum_t'(v);
  assign h_in  = (h_ext >= hwin.start) && (h_ext < hwin.stop);
  assign v_in  = (v_ext >= vwin.start) && (v_ext < vwin.stop);
  assign de_c  = h_in && v_in;
  assign x_c   = de_c ? CNT_WIDTH'(h_ext - hwin.start) : '0;
  assign y_c   = de_c ? CNT_WIDTH'(v_ext - vwin.start) : '0;
  assign hs_c  = h_ext < tsum_t'(act_cfg.h_sync);
  assign vs_c  = v_ext < tsum_t'(act_cfg.v_sync);
  assign sof_c = de_c && (h_ext == hwin.start) && (v_ext == vwin.start);
  assign eol_c = de_c && ((h_ext + tsum_t'(PPC)) == hwin.stop);

  // Syncs keep their last level while held; everything else is blanked.
  always_ff @(posedge in_pclk) begin
    if (in_rst) begin
      out_de  <= 1'b0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
      out_hs  <= ~HS_ON;
      out_vs  <= ~VS_ON;
    end else if (adv) begin
      out_de  <= de_c;
      out_sof <= sof_c;
      out_eol <= eol_c;
      out_x   <= x_c;
      out_y   <= y_c;
      out_hs  <= hs_c ? HS_ON : ~HS_ON;
      out_vs  <= vs_c ? VS_ON : ~VS_ON;
    end else begin
      out_de  <= 1'b0;
      out_sof <= 1'b0;
      out_eol <= 1'b0;
      out_x   <= '0;
      out_y   <= '0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Two generators (PPC=1 active-high HS, PPC=2 active-high VS) driven in lockstep
// and checked every cycle against a frame-position reference model.
module tb_video_timing_gen;

  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst, en, load;
  logic [CW-1:0] cfg_v[8];
  logic pend_o[2], de_o[2], hs_o[2], vs_o[2], sof_o[2], eol_o[2];
  logic [CW-1:0] x_o[2], y_o[2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CNT_WIDTH(CW), .PPC(1), .HS_ACTIVE_HIGH(1'b1), .VS_ACTIVE_HIGH(1'b0),
    .DEF_H_SYNC(2), .DEF_H_BP(2), .DEF_H_ACT(4), .DEF_H_FP(2),
    .DEF_V_SYNC(1), .DEF_V_BP(1), .DEF_V_ACT(3), .DEF_V_FP(1)
  ) dut0 (
    .in_pclk(clk), .in_rst(rst), .in_enable(en), .in_cfg_load(load),
    .in_cfg_h_sync(cfg_v[0]), .in_cfg_h_bp(cfg_v[1]), .in_cfg_h_act(cfg_v[2]), .in_cfg_h_fp(cfg_v[3]),
    .in_cfg_v_sync(cfg_v[4]), .in_cfg_v_bp(cfg_v[5]), .in_cfg_v_act(cfg_v[6]), .in_cfg_v_fp(cfg_v[7]),
    .out_cfg_pending(pend_o[0]), .out_x(x_o[0]), .out_y(y_o[0]), .out_de(de_o[0]),
    .out_hs(hs_o[0]), .out_vs(vs_o[0]), .out_sof(sof_o[0]), .out_eol(eol_o[0])
  );

  video_timing_gen #(
    .CNT_WIDTH(CW), .PPC(2), .HS_ACTIVE_HIGH(1'b0), .VS_ACTIVE_HIGH(1'b1),
    .DEF_H_SYNC(2), .DEF_H_BP(2), .DEF_H_ACT(4), .DEF_H_FP(2),
    .DEF_V_SYNC(1), .DEF_V_BP(1), .DEF_V_ACT(3), .DEF_V_FP(1)
  ) dut1 (
    .in_pclk(clk), .in_rst(rst), .in_enable(en), .in_cfg_load(load),
    .in_cfg_h_sync(cfg_v[0]), .in_cfg_h_bp(cfg_v[1]), .in_cfg_h_act(cfg_v[2]), .in_cfg_h_fp(cfg_v[3]),
    .in_cfg_v_sync(cfg_v[4]), .in_cfg_v_bp(cfg_v[5]), .in_cfg_v_act(cfg_v[6]), .in_cfg_v_fp(cfg_v[7]),
    .out_cfg_pending(pend_o[1]), .out_x(x_o[1]), .out_y(y_o[1]), .out_de(de_o[1]),
    .out_hs(hs_o[1]), .out_vs(vs_o[1]), .out_sof(sof_o[1]), .out_eol(eol_o[1])
  );

  // Reference: each DUT is a beat position p inside the frame; h and v follow by division.
  int def_cfg[8] = '{2, 2, 4, 2, 1, 1, 3, 1};
  int a_cfg[2][8];
  int p_cfg[2][8];
  int m_p[2];
  bit m_run[2], m_pend[2];
  bit e_de[2], e_hs[2], e_vs[2], e_sof[2], e_eol[2], e_pend[2];
  int e_x[2], e_y[2];

  function automatic int line_beats(int k);
    return (a_cfg[k][0] + a_cfg[k][1] + a_cfg[k][2] + a_cfg[k][3]) / (k + 1);
  endfunction

  function automatic int frame_lines(int k);
    return a_cfg[k][4] + a_cfg[k][5] + a_cfg[k][6] + a_cfg[k][7];
  endfunction

  function automatic bit wraps_next(int k);
    if (rst || !en || !m_run[k]) return 1'b0;
    return (m_p[k] + 1) == line_beats(k) * frame_lines(k);
  endfunction

  task automatic model_step(input int k);
    int pp, lb, h, v, hs0, vs0;
    bit wrap;
    pp = k + 1;
    wrap = 1'b0;
    if (rst) begin
      m_p[k] = 0; m_run[k] = 1'b0; m_pend[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin a_cfg[k][i] = def_cfg[i]; p_cfg[k][i] = def_cfg[i]; end
      e_de[k] = 0; e_sof[k] = 0; e_eol[k] = 0; e_x[k] = 0; e_y[k] = 0;
      e_hs[k] = (k != 0); e_vs[k] = (k != 1);
    end else begin
      if (en && m_run[k]) begin
        lb = line_beats(k);
        h = (m_p[k] % lb) * pp;
        v = m_p[k] / lb;
        hs0 = a_cfg[k][0] + a_cfg[k][1];
        vs0 = a_cfg[k][4] + a_cfg[k][5];
        e_de[k]  = (h >= hs0) && (h < hs0 + a_cfg[k][2]) && (v >= vs0) && (v < vs0 + a_cfg[k][6]);
        e_x[k]   = e_de[k] ? h - hs0 : 0;
        e_y[k]   = e_de[k] ? v - vs0 : 0;
        e_hs[k]  = (h < a_cfg[k][0]) ? (k == 0) : (k != 0);
        e_vs[k]  = (v < a_cfg[k][4]) ? (k == 1) : (k != 1);
        e_sof[k] = e_de[k] && e_x[k] == 0 && e_y[k] == 0;
        e_eol[k] = e_de[k] && e_x[k] == a_cfg[k][2] - pp;
        wrap = (m_p[k] + 1) == lb * frame_lines(k);
        m_p[k] = wrap ? 0 : m_p[k] + 1;
      end else begin
        if (en) m_run[k] = 1'b1;
        e_de[k] = 0; e_sof[k] = 0; e_eol[k] = 0; e_x[k] = 0; e_y[k] = 0;
      end
      if (load) begin
        for (int i = 0; i < 8; i++) p_cfg[k][i] = int'(cfg_v[i]);
        m_pend[k] = 1'b1;
      end else if (wrap && m_pend[k]) begin
        for (int i = 0; i < 8; i++) a_cfg[k][i] = p_cfg[k][i];
        m_pend[k] = 1'b0;
      end
    end
    e_pend[k] = m_pend[k];
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("dut%0d de", k),  32'(de_o[k]),  32'(e_de[k]));
    chk($sformatf("dut%0d hs", k),  32'(hs_o[k]),  32'(e_hs[k]));
    chk($sformatf("dut%0d vs", k),  32'(vs_o[k]),  32'(e_vs[k]));
    chk($sformatf("dut%0d sof", k), 32'(sof_o[k]), 32'(e_sof[k]));
    chk($sformatf("dut%0d eol", k), 32'(eol_o[k]), 32'(e_eol[k]));
    chk($sformatf("dut%0d x", k),   32'(x_o[k]),   32'(e_x[k]));
    chk($sformatf("dut%0d y", k),   32'(y_o[k]),   32'(e_y[k]));
    chk($sformatf("dut%0d pending", k), 32'(pend_o[k]), 32'(e_pend[k]));
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare(0);
    compare(1);
  endtask

  task automatic set_cfg(input int hs, hb, ha, hf, vs, vb, va, vf);
    cfg_v[0] = CW'(hs); cfg_v[1] = CW'(hb); cfg_v[2] = CW'(ha); cfg_v[3] = CW'(hf);
    cfg_v[4] = CW'(vs); cfg_v[5] = CW'(vb); cfg_v[6] = CW'(va); cfg_v[7] = CW'(vf);
  endtask

  initial begin
    int de_cnt[2], sof_cnt[2];
    rst = 1'b1; en = 1'b1; load = 1'b0;
    set_cfg(2, 2, 4, 2, 1, 1, 3, 1);
    tick(); tick();
    rst = 1'b0;

    // Default small raster: frame 60 clocks at PPC=1, 30 clocks at PPC=2.
    de_cnt = '{0, 0}; sof_cnt = '{0, 0};
    repeat (130) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (de_o[k] === 1'b1) de_cnt[k]++;
        if (sof_o[k] === 1'b1) sof_cnt[k]++;
      end
    end
    chk("dut0 de beats 130 clk", 32'(de_cnt[0]), 32'd24);
    chk("dut0 sof count",        32'(sof_cnt[0]), 32'd2);
    chk("dut1 de beats 130 clk", 32'(de_cnt[1]), 32'd24);
    chk("dut1 sof count",        32'(sof_cnt[1]), 32'd4);

    // Mid-frame reprogram to h_act=6.
    set_cfg(2, 2, 6, 2, 1, 1, 3, 1);
    load = 1'b1; tick(); load = 1'b0;
    chk("pending after load", 32'(pend_o[0]), 32'd1);
    repeat (200) tick();

    // Load landing exactly on dut0's frame wrap waits a full frame.
    for (int n = 0; n < 300 && !wraps_next(0); n++) tick();
    chk("wrap edge found", 32'(wraps_next(0)), 32'd1);
    set_cfg(2, 2, 4, 2, 1, 1, 3, 1);
    load = 1'b1; tick(); load = 1'b0;
    chk("pending held over wrap", 32'(pend_o[0]), 32'd1);
    repeat (150) tick();

    // Hold for 7 clocks while the counter sits on the second active pixel.
    for (int n = 0; n < 300 && !(e_de[0] && e_x[0] == 0); n++) tick();
    chk("hold point found", 32'(e_de[0] && e_x[0] == 0), 32'd1);
    en = 1'b0;
    repeat (7) tick();
    en = 1'b1;
    tick();
    chk("resume de", 32'(de_o[0]), 32'd1);
    chk("resume x",  32'(x_o[0]),  32'd1);
    repeat (40) tick();

    // Reset mid-line.
    for (int n = 0; n < 300 && !e_de[0]; n++) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("reset hs inactive", 32'(hs_o[0]), 32'd0);
    chk("reset de", 32'(de_o[0]), 32'd0);
    tick(); tick();
    chk("hs active high after reset", 32'(hs_o[0]), 32'd1);
    chk("vs active high after reset", 32'(vs_o[1]), 32'd1);

    // Randomised enables, reprogramming and occasional resets.
    repeat (1500) begin
      en   = ($urandom_range(0, 9) != 0);
      load = ($urandom_range(0, 29) == 0);
      rst  = ($urandom_range(0, 399) == 0);
      if (load)
        set_cfg(2 * $urandom_range(0, 2), 2 * $urandom_range(0, 2), 2 * $urandom_range(1, 4),
                2 * $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(1, 4), $urandom_range(0, 2));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
